// File: rtl/hnf_txreq_arb.sv
// HN-F TXREQ link controller: arbitrates requesters onto the single TXREQ
// channel, tracks SN-F L-credits and sequences link activate/deactivate.
//
// Ports:
//   clock, reset_n        clock, async active-low reset
//   link_en               1 = bring up / keep up the link, 0 = take it down
//   req_flit/req_valid    per-requester flit and valid
//   req_ready             one-hot grant (flit accepted when valid&ready)
//   txreqflit/txreqflitv  registered flit and valid to the SN-F
//   txreqflitpend         flit-pending indicator
//   txreqlcrdv            one L-credit granted per asserted cycle
//   txlinkactivereq/ack   link activation handshake
//   lcrd_cnt              credits currently held (debug)
//   lcrd_ovf              sticky: credit received while counter full
//
// Build option: define HNF_TXREQ_QOS_EN to arbitrate by highest QoS
// (round-robin tie-break) and tag credit-return flits with QoS=4'hF.

package hnf_txreq_pkg;

  typedef struct packed {
    logic [3:0]  QoS;
    logic [6:0]  TgtID;
    logic [6:0]  SrcID;
    logic [7:0]  TxnID;
    logic [5:0]  Opcode;
    logic [2:0]  Size;
    logic [43:0] Addr;
  } reqflit_t;

  localparam logic [5:0] OPC_LCRD_RETURN = 6'h00;

endpackage

module hnf_txreq_arb
  import hnf_txreq_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  parameter  int MAX_LCRD = 15,
  localparam int CW = $clog2(MAX_LCRD + 1),
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     link_en,
  input  reqflit_t [NUM_REQ-1:0]   req_flit,
  input  logic     [NUM_REQ-1:0]   req_valid,
  output logic     [NUM_REQ-1:0]   req_ready,
  output reqflit_t                 txreqflit,
  output logic                     txreqflitv,
  output logic                     txreqflitpend,
  input  logic                     txreqlcrdv,
  output logic                     txlinkactivereq,
  input  logic                     txlinkactiveack,
  output logic     [CW-1:0]        lcrd_cnt,
  output logic                     lcrd_ovf
);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_ACT,
    ST_RUN,
    ST_DEACT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [RW-1:0]   rr_q, rr_d;
  reqflit_t        flit_q, flit_d;
  logic            flitv_q, flitv_d;

  logic                have_crd;
  logic [NUM_REQ-1:0]  grant;
  logic [RW-1:0]       gnt_idx;
  logic                gnt_vld;
  reqflit_t            rtn_flit;
  logic                rtn_vld;

  // The flit on the wire still holds its credit until the decrement
  // at the end of this cycle, so it must not be spent twice.
  always_comb begin
    if (flitv_q) have_crd = (cnt_q > CW'(1));
    else         have_crd = (cnt_q != '0);
  end

  always_comb begin
    logic [RW-1:0] idx;
    logic          qos_ok;
`ifdef HNF_TXREQ_QOS_EN
    logic [3:0]    best_qos;
    best_qos = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (req_flit[i].QoS > best_qos))
        best_qos = req_flit[i].QoS;
    end
`endif
    grant   = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    qos_ok  = 1'b0;
    if ((state_q == ST_RUN) && have_crd) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = RW'((int'(rr_q) + k) % NUM_REQ);
`ifdef HNF_TXREQ_QOS_EN
        qos_ok = (req_flit[idx].QoS == best_qos);
`else
        qos_ok = 1'b1;
`endif
        if (!gnt_vld && req_valid[idx] && qos_ok) begin
          gnt_vld      = 1'b1;
          gnt_idx      = idx;
          grant[idx]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rtn_flit        = '0;
    rtn_flit.Opcode = OPC_LCRD_RETURN;
    rtn_flit.TgtID  = flit_q.TgtID;
    rtn_flit.SrcID  = flit_q.SrcID;
`ifdef HNF_TXREQ_QOS_EN
    rtn_flit.QoS    = 4'hF;
`else
    rtn_flit.QoS    = 4'h0;
`endif
    rtn_vld = (state_q == ST_DEACT) && have_crd;
  end

  always_comb begin
    flitv_d = gnt_vld | rtn_vld;
    flit_d  = flit_q;
    if (gnt_vld)      flit_d = req_flit[gnt_idx];
    else if (rtn_vld) flit_d = rtn_flit;
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_vld) begin
      if (gnt_idx == RW'(NUM_REQ - 1)) rr_d = '0;
      else                             rr_d = gnt_idx + RW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case ({txreqlcrdv, flitv_q})
      2'b10: begin
        if (cnt_q == CW'(MAX_LCRD)) ovf_d = 1'b1;
        else                        cnt_d = cnt_q + CW'(1);
      end
      2'b01: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP:
        if (link_en && !txlinkactiveack) state_d = ST_ACT;
      ST_ACT:
        if (txlinkactiveack) state_d = ST_RUN;
      ST_RUN:
        if (!link_en) state_d = ST_DEACT;
      ST_DEACT:
        if ((cnt_q == '0) && !txlinkactiveack && !flitv_q)
          state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rr_q    <= '0;
      flit_q  <= '0;
      flitv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rr_q    <= rr_d;
      flit_q  <= flit_d;
      flitv_q <= flitv_d;
    end
  end

  assign req_ready       = grant;
  assign txreqflit       = flit_q;
  assign txreqflitv      = flitv_q;
  assign lcrd_cnt        = cnt_q;
  assign lcrd_ovf        = ovf_q;
  assign txlinkactivereq = (state_q == ST_ACT) ||
                           (state_q == ST_RUN);
  assign txreqflitpend   = (state_q == ST_RUN) ||
                           (state_q == ST_DEACT);

endmodule

// File: tb/tb_hnf_txreq_arb.sv
// Directed self-checking bench for hnf_txreq_arb.
// Scenario tasks run in sequence from one initial block.

module tb_hnf_txreq_arb;
  import hnf_txreq_pkg::*;

  localparam int NR = 2;
  localparam int CW = 4;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 link_en;
  reqflit_t [NR-1:0]    req_flit;
  logic     [NR-1:0]    req_valid;
  logic     [NR-1:0]    req_ready;
  reqflit_t             txreqflit;
  logic                 txreqflitv;
  logic                 txreqflitpend;
  logic                 txreqlcrdv;
  logic                 txlinkactivereq;
  logic                 txlinkactiveack;
  logic     [CW-1:0]    lcrd_cnt;
  logic                 lcrd_ovf;

  int checks = 0;
  int errors = 0;
  reqflit_t fa, fb, rtn;

  hnf_txreq_arb #(.NUM_REQ(NR), .MAX_LCRD(15)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .link_en         (link_en),
    .req_flit        (req_flit),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .txreqflit       (txreqflit),
    .txreqflitv      (txreqflitv),
    .txreqflitpend   (txreqflitpend),
    .txreqlcrdv      (txreqlcrdv),
    .txlinkactivereq (txlinkactivereq),
    .txlinkactiveack (txlinkactiveack),
    .lcrd_cnt        (lcrd_cnt),
    .lcrd_ovf        (lcrd_ovf)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; link_en = 1'b0; txreqlcrdv = 1'b0;
    txlinkactiveack = 1'b0; req_valid = '0; req_flit = '0;
    cyc();
    checks++;
    if ({txreqflitv, txlinkactivereq, txreqflitpend, lcrd_ovf} !== 4'b0) begin
      errors++;
      $display("FAIL rst_ctl got %b exp 0000",
        {txreqflitv, txlinkactivereq, txreqflitpend, lcrd_ovf});
    end
    checks++;
    if (lcrd_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_cnt got %0d exp 0", lcrd_cnt);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL rst_ready got %b exp 00", req_ready);
    end
    checks++;
    if (txreqflit !== reqflit_t'('0)) begin
      errors++; $display("FAIL rst_flit got %h exp 0", txreqflit);
    end
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_activation();
    link_en = 1'b1;
    cyc();
    checks++;
    if (txlinkactivereq !== 1'b1) begin
      errors++; $display("FAIL act_req got %b exp 1", txlinkactivereq);
    end
    checks++;
    if (txreqflitpend !== 1'b0) begin
      errors++; $display("FAIL act_pend got %b exp 0", txreqflitpend);
    end
    cyc(); cyc();
    txlinkactiveack = 1'b1;
    cyc();
    checks++;
    if ({txreqflitpend, txlinkactivereq} !== 2'b11) begin
      errors++;
      $display("FAIL run_pend got %b exp 11",
        {txreqflitpend, txlinkactivereq});
    end
  endtask

  task automatic test_credits();
    fa = '0; fa.Opcode = 6'h04; fa.TxnID = 8'h11;
    fa.TgtID = 7'h05; fa.SrcID = 7'h03; fa.Addr = 44'h1000;
    fb = '0; fb.Opcode = 6'h04; fb.TxnID = 8'h22;
    fb.TgtID = 7'h06; fb.SrcID = 7'h03; fb.Addr = 44'h2000;
    req_flit[0] = fa; req_flit[1] = fb;
    txreqlcrdv = 1'b1;
    cyc(); cyc();
    txreqlcrdv = 1'b0;
    checks++;
    if (lcrd_cnt !== 4'd2) begin
      errors++; $display("FAIL crd_cnt2 got %0d exp 2", lcrd_cnt);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL gnt_r0 got %b exp 01", req_ready);
    end
    cyc();
    checks++;
    if (txreqflitv !== 1'b1 || txreqflit !== fa) begin
      errors++;
      $display("FAIL issue_r0 got v=%b %h exp v=1 %h", txreqflitv, txreqflit, fa);
    end
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL gnt_r1 got %b exp 10", req_ready);
    end
    cyc();
    checks++;
    if (txreqflitv !== 1'b1 || txreqflit !== fb) begin
      errors++;
      $display("FAIL issue_r1 got v=%b %h exp v=1 %h", txreqflitv, txreqflit, fb);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL stall_gnt got %b exp 00", req_ready);
    end
    cyc();
    checks++;
    if (txreqflitv !== 1'b0 || lcrd_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stall got v=%b cnt=%0d exp v=0 cnt=0", txreqflitv, lcrd_cnt);
    end
    checks++;
    if (txreqflit !== fb) begin
      errors++; $display("FAIL flit_hold got %h exp %h", txreqflit, fb);
    end
    for (int j = 0; j < 2; j++) begin
      txreqlcrdv = 1'b1;
      cyc();
      txreqlcrdv = 1'b0;
      checks++;
      if (req_ready !== (2'b01 << j)) begin
        errors++;
        $display("FAIL crd_gnt%0d got %b exp %b", j, req_ready, 2'b01 << j);
      end
      cyc();
      checks++;
      if (txreqflitv !== 1'b1 || txreqflit !== ((j == 0) ? fa : fb)) begin
        errors++;
        $display("FAIL crd_issue%0d got v=%b %h", j, txreqflitv, txreqflit);
      end
      cyc();
      checks++;
      if (txreqflitv !== 1'b0 || lcrd_cnt !== 4'd0) begin
        errors++;
        $display("FAIL crd_stall%0d got v=%b cnt=%0d exp v=0 cnt=0",
          j, txreqflitv, lcrd_cnt);
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_simultaneous();
    txreqlcrdv = 1'b1;
    cyc();
    txreqlcrdv = 1'b0;
    checks++;
    if (lcrd_cnt !== 4'd1) begin
      errors++; $display("FAIL sim_cnt1 got %0d exp 1", lcrd_cnt);
    end
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL sim_gnt got %b exp 01", req_ready);
    end
    cyc();
    txreqlcrdv = 1'b1;
    #1;
    checks++;
    if (txreqflitv !== 1'b1 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL sim_issue got v=%b rdy=%b exp v=1 rdy=00", txreqflitv, req_ready);
    end
    cyc();
    txreqlcrdv = 1'b0;
    #1;
    checks++;
    if (lcrd_cnt !== 4'd1) begin
      errors++; $display("FAIL sim_cnt_hold got %0d exp 1", lcrd_cnt);
    end
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL sim_regrant got %b exp 01", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    checks++;
    if (txreqflitv !== 1'b1 || txreqflit !== fa) begin
      errors++;
      $display("FAIL sim_issue2 got v=%b %h exp v=1 %h", txreqflitv, txreqflit, fa);
    end
    cyc();
    checks++;
    if (lcrd_cnt !== 4'd0) begin
      errors++; $display("FAIL sim_cnt0 got %0d exp 0", lcrd_cnt);
    end
  endtask

  task automatic test_deactivate();
    int nflits;
    txreqlcrdv = 1'b1;
    repeat (3) cyc();
    txreqlcrdv = 1'b0;
    checks++;
    if (lcrd_cnt !== 4'd3) begin
      errors++; $display("FAIL dea_cnt3 got %0d exp 3", lcrd_cnt);
    end
    link_en = 1'b0;
    cyc();
    req_valid = 2'b11;
    #1;
    checks++;
    if ({txlinkactivereq, txreqflitpend} !== 2'b01) begin
      errors++;
      $display("FAIL dea_state got %b exp 01", {txlinkactivereq, txreqflitpend});
    end
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL dea_nogrant got %b exp 00", req_ready);
    end
    rtn = '0;
    rtn.Opcode = 6'h00;
    rtn.TgtID = fa.TgtID;
    rtn.SrcID = fa.SrcID;
`ifdef HNF_TXREQ_QOS_EN
    rtn.QoS = 4'hF;
`endif
    nflits = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      txreqlcrdv = (c == 0);
      if (c == 2) link_en = 1'b1;
      if (txreqflitv === 1'b1) begin
        nflits++;
        checks++;
        if (txreqflit !== rtn) begin
          errors++;
          $display("FAIL rtn_flit%0d got %h exp %h", c, txreqflit, rtn);
        end
      end
    end
    checks++;
    if (nflits !== 4) begin
      errors++; $display("FAIL rtn_count got %0d exp 4", nflits);
    end
    checks++;
    if (lcrd_cnt !== 4'd0) begin
      errors++; $display("FAIL rtn_cnt0 got %0d exp 0", lcrd_cnt);
    end
    checks++;
    if ({txlinkactivereq, txreqflitpend} !== 2'b01) begin
      errors++;
      $display("FAIL dea_hold got %b exp 01", {txlinkactivereq, txreqflitpend});
    end
    txlinkactiveack = 1'b0;
    req_valid = 2'b00;
    cyc();
    checks++;
    if ({txlinkactivereq, txreqflitpend} !== 2'b00) begin
      errors++;
      $display("FAIL stop_reached got %b exp 00", {txlinkactivereq, txreqflitpend});
    end
    cyc();
    checks++;
    if (txlinkactivereq !== 1'b1) begin
      errors++; $display("FAIL reactivate got %b exp 1", txlinkactivereq);
    end
  endtask

  task automatic test_overflow();
    txreqlcrdv = 1'b1;
    repeat (15) cyc();
    checks++;
    if (lcrd_cnt !== 4'd15 || lcrd_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full got cnt=%0d ovf=%b exp 15 0", lcrd_cnt, lcrd_ovf);
    end
    cyc();
    txreqlcrdv = 1'b0;
    checks++;
    if (lcrd_cnt !== 4'd15 || lcrd_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got cnt=%0d ovf=%b exp 15 1", lcrd_cnt, lcrd_ovf);
    end
  endtask

  task automatic test_async_reset();
    txlinkactiveack = 1'b1;
    cyc();
    req_valid = 2'b11;
    cyc(); cyc();
    checks++;
    if (txreqflitv !== 1'b1) begin
      errors++; $display("FAIL burst_v got %b exp 1", txreqflitv);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({txreqflitv, txlinkactivereq, txreqflitpend, lcrd_ovf} !== 4'b0 ||
        lcrd_cnt !== 4'd0 || req_ready !== 2'b00 ||
        txreqflit !== reqflit_t'('0)) begin
      errors++;
      $display("FAIL async_rst got v=%b req=%b pend=%b ovf=%b cnt=%0d rdy=%b",
        txreqflitv, txlinkactivereq, txreqflitpend, lcrd_ovf, lcrd_cnt, req_ready);
    end
    req_valid = 2'b00;
    cyc();
    reset_n = 1'b1;
    cyc();
    checks++;
    if ({txlinkactivereq, txreqflitpend} !== 2'b00) begin
      errors++;
      $display("FAIL stop_after_rst got %b exp 00", {txlinkactivereq, txreqflitpend});
    end
  endtask

`ifdef HNF_TXREQ_QOS_EN
  task automatic test_qos();
    txlinkactiveack = 1'b0;
    link_en = 1'b1;
    cyc();
    txlinkactiveack = 1'b1;
    cyc();
    fa.QoS = 4'h2; fb.QoS = 4'h9;
    req_flit[0] = fa; req_flit[1] = fb;
    txreqlcrdv = 1'b1;
    cyc();
    txreqlcrdv = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL qos_gnt got %b exp 10", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    checks++;
    if (txreqflitv !== 1'b1 || txreqflit !== fb) begin
      errors++;
      $display("FAIL qos_issue got v=%b %h exp v=1 %h", txreqflitv, txreqflit, fb);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_activation();
    test_credits();
    test_simultaneous();
    test_deactivate();
    test_overflow();
    test_async_reset();
`ifdef HNF_TXREQ_QOS_EN
    test_qos();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hnf_txreq_arb.md
Name: hnf_txreq_arb

Overview:
Controller for the HN-F TXREQ link to the SN-F. It shares the single TXREQ flit channel between NUM_REQ internal requesters (ReadNoSnp, WriteNoSnp, etc.), tracks L-credits granted by the SN-F, and sequences link activation and deactivation. On deactivation it returns every held credit with ReqLCrdReturn flits. It sits between the HN-F request-generation queues and the CHI TX link pins.

Parameters:
NUM_REQ, 2, number of requesters sharing TXREQ (1..8)
MAX_LCRD, 15, maximum L-credits the SN-F may grant (CHI limit); counter width is $clog2(MAX_LCRD+1)

Ports:
clock  input  1  single clock
reset_n  input  1  asynchronous, active-low reset
link_en  input  1  1 = bring the link up / keep it up; 0 = take it down
req_flit  input  NUM_REQ x reqflit_t  per-requester flit
req_valid  input  NUM_REQ  per-requester flit valid
req_ready  output  NUM_REQ  one-hot grant; flit accepted when valid&ready
txreqflit  output  reqflit_t  flit to SN-F, registered
txreqflitv  output  1  flit valid, registered
txreqflitpend  output  1  flit-pending indicator
txreqlcrdv  input  1  one L-credit granted per cycle asserted
txlinkactivereq  output  1  link activation request
txlinkactiveack  input  1  link activation acknowledge
lcrd_cnt  output  $clog2(MAX_LCRD+1)  credits currently held (debug)
lcrd_ovf  output  1  sticky error: credit received while counter = MAX_LCRD

Behaviour:
- Reset (async assert, sync deassert): state STOP, lcrd_cnt=0, txreqflitv=0, txreqflit=0, txlinkactivereq=0, req_ready=0, lcrd_ovf=0, rr pointer=0.
- Link FSM:
  - STOP: req=0. Moves to ACTIVATE when link_en=1 and ack=0.
  - ACTIVATE: req=1. Moves to RUN when ack=1.
  - RUN: req=1. Moves to DEACTIVATE when link_en=0.
  - DEACTIVATE: req=0. Moves to STOP when lcrd_cnt=0, ack=0, and no return flit is in flight.
- txreqflitpend = 1 in RUN and DEACTIVATE, 0 otherwise.
- Credits:
  - Counter increments on txreqlcrdv in any state and decrements on every cycle txreqflitv=1.
  - Same-cycle increment and decrement leaves the count unchanged.
  - Increment at MAX_LCRD is dropped and sets lcrd_ovf.
- Grant (combinational req_ready):
  - Grants only in RUN, with lcrd_cnt>0 and at least one req_valid.
  - At most one grant per cycle.
  - Round-robin: search starts at rr pointer; after a grant to i, pointer becomes (i+1) mod NUM_REQ.
  - A credit arriving in cycle N is usable in cycle N+1.
- Issue latency: a grant in cycle N drives txreqflit=req_flit[i] and txreqflitv=1 in cycle N+1. With no grant, txreqflitv=0 and txreqflit holds its last value.
- DEACTIVATE:
  - No requester grants.
  - Each cycle with lcrd_cnt>0 issues one return flit: Opcode=6'h00 (ReqLCrdReturn), TxnID=0, TgtID/SrcID copied from the last issued flit, all other fields 0. This consumes one credit.
  - Credits arriving during DEACTIVATE are also returned.
- link_en toggling back to 1 during DEACTIVATE is ignored until STOP is reached.
- Back-to-back issue: one flit per cycle sustained while credits are available.

Optional Feature:
HNF_TXREQ_QOS_EN
- Defined: the grant goes to the valid requester with the highest req_flit[i].QoS. Ties are broken round-robin from the rr pointer, and the pointer updates as normal. Return flits carry QoS=4'hF.
- Undefined: pure round-robin, QoS ignored by arbitration, return flits carry QoS=0.

Test Plan:
- Activation: reset, link_en=1, ack asserted 3 cycles later -> txlinkactivereq=1 from cycle 1; RUN and txreqflitpend=1 the cycle after ack.
- Credits: in RUN, 2 credits, req_valid=2'b11 held, 4 flits each -> exactly 2 flits issued (req0 then req1), then stall with lcrd_cnt=0. Each further credit yields one flit, alternating requesters.
- Simultaneous credit and issue: lcrd_cnt=1, credit arrives the same cycle a flit is granted -> lcrd_cnt stays 1 and the next flit is issued the following cycle.
- Deactivate: lcrd_cnt=3, link_en=0 -> txlinkactivereq=0, three consecutive Opcode=0 flits. A credit arriving mid-return produces a 4th return flit. STOP is reached after ack=0 and lcrd_cnt=0.
- Overflow and reset: 16 credits with MAX_LCRD=15 -> lcrd_cnt=15, lcrd_ovf=1. Async reset_n=0 mid-burst -> all outputs 0 immediately, state STOP.
- With HNF_TXREQ_QOS_EN: req0 QoS=2, req1 QoS=9, both valid, 1 credit -> req1 granted first.
